// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words, holds the CPU in reset while loading, then releases it to run.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  len,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] a,
  output logic [31:0] rd,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t         state_q, state_d;
  logic [6:0]     len_q, len_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [1:0]     idx_q, idx_d;
  logic [31:0]    asm_q, asm_d;
  logic           err_q, err_d;
  logic           ram_we;
  logic [31:0]    ram_wdata;
  logic [31:0]    mem [DEPTH];
  logic           len_ok;
  logic           last_word;
  logic           unused_a;

  assign len_ok    = (len != 7'd0) && ({1'b0, len} <= DEPTH_L);
  assign last_word = ({{(7-AW){1'b0}}, wptr_q} == (len_q - 7'd1));
  assign unused_a  = ^{a[31:AW+2], a[1:0]};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wptr_d    = wptr_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_wdata = {rx_data, asm_q[23:0]};
    case (state_q)
      // IDLE and RUN react to start identically; only the outputs differ.
      IDLE, RUN: begin
        if (start) begin
          if (len_ok) begin
            state_d = LOAD;
            len_d   = len;
            err_d   = 1'b0;
            wptr_d  = '0;
            idx_d   = 2'd0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (rx_valid) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            default: begin
              ram_we = 1'b1;
              wptr_d = wptr_q + AW'(1);
              if (last_word) state_d = RUN;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= 7'd0;
      wptr_q  <= '0;
      idx_q   <= 2'd0;
      asm_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
    end
  end

  // Program RAM survives reset so an aborted load keeps its finished words.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wptr_q] <= ram_wdata;
  end

  assign rd        = mem[a[AW+1:2]];
  assign cpu_reset = (state_q != RUN);
  assign rx_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == RUN);
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader: a table of per-cycle stimulus with
// expected flags/rd, plus hand-written async-reset sequences.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] a;
  logic [31:0] rd;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .a(a), .rd(rd), .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: {cpu_reset, rx_ready, busy, done, err}
  localparam logic [4:0] F_IDLE   = 5'b10000;
  localparam logic [4:0] F_IDLE_E = 5'b10001;
  localparam logic [4:0] F_LOAD   = 5'b11100;
  localparam logic [4:0] F_RUN    = 5'b00010;

  typedef struct {
    logic        st;
    logic [6:0]  ln;
    logic        vl;
    logic [7:0]  d;
    logic [31:0] addr;
    logic [4:0]  f;
    logic        crd;
    logic [31:0] erd;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic st, logic [6:0] ln, logic vl, logic [7:0] d,
                              logic [31:0] addr, logic [4:0] f, logic crd,
                              logic [31:0] erd);
    vec_t v;
    v.st = st; v.ln = ln; v.vl = vl; v.d = d;
    v.addr = addr; v.f = f; v.crd = crd; v.erd = erd;
    return v;
  endfunction

  function automatic logic [4:0] flags();
    return {cpu_reset, rx_ready, busy, done, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [6:0] ln, input logic vl,
                       input logic [7:0] d);
    start = st; len = ln; rx_valid = vl; rx_data = d;
  endtask

  task automatic step(input logic st, input logic [6:0] ln, input logic vl,
                      input logic [7:0] d);
    drive(st, ln, vl, d);
    @(posedge clk);
    #1;
  endtask

  task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [4:0] last_f);
    vq.push_back(mk(1'b0, 7'd0, 1'b1, b0, 32'd0, F_LOAD, 1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, b1, 32'd0, F_LOAD, 1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, b2, 32'd0, F_LOAD, 1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, b3, 32'd0, last_f, 1'b0, 32'd0));
  endtask

  initial begin
    reset = 1'b1;
    a = 32'd0;
    drive(1'b0, 7'd0, 1'b0, 8'h00);

    // Reset state, invalid lengths in IDLE, then a two-word program.
    vq.push_back(mk(1'b0, 7'd0,  1'b0, 8'h00, 32'd0, F_IDLE,   1'b0, 32'd0));
    vq.push_back(mk(1'b1, 7'd0,  1'b0, 8'h00, 32'd0, F_IDLE_E, 1'b0, 32'd0));
    vq.push_back(mk(1'b1, 7'd65, 1'b0, 8'h00, 32'd0, F_IDLE_E, 1'b0, 32'd0));
    vq.push_back(mk(1'b1, 7'd2,  1'b0, 8'h00, 32'd0, F_LOAD,   1'b0, 32'd0));
    load_bytes(8'h13, 8'h00, 8'h50, 8'h00, F_LOAD);
    load_bytes(8'h93, 8'h02, 8'h40, 8'h00, F_RUN);
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'h00, 32'd0, F_RUN, 1'b1, 32'h00500013));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'hFF, 32'd4, F_RUN, 1'b1, 32'h00400293));
    // Invalid start in RUN drops to IDLE; then len=1 with a stalling stream.
    vq.push_back(mk(1'b1, 7'd0, 1'b0, 8'h00, 32'd0, F_IDLE_E, 1'b0, 32'd0));
    vq.push_back(mk(1'b1, 7'd1, 1'b0, 8'h00, 32'd0, F_LOAD,   1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'hEF, 32'd0, F_LOAD,   1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'hFF, 32'd0, F_LOAD,   1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'hFF, 32'd0, F_LOAD,   1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'hBE, 32'd0, F_LOAD,   1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'hAD, 32'd0, F_LOAD,   1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'hFF, 32'd0, F_LOAD,   1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'hDE, 32'd0, F_RUN,    1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'h00, 32'd0, F_RUN, 1'b1, 32'hDEADBEEF));
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'h00, 32'd4, F_RUN, 1'b1, 32'h00400293));
    // Reload straight from RUN; word 1 must keep its old contents.
    vq.push_back(mk(1'b1, 7'd1, 1'b0, 8'h00, 32'd0, F_LOAD, 1'b0, 32'd0));
    load_bytes(8'h78, 8'h56, 8'h34, 8'h12, F_RUN);
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'h00, 32'd0, F_RUN, 1'b1, 32'h12345678));
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'h00, 32'd4, F_RUN, 1'b1, 32'h00400293));
    // start with len=5 mid-load must not re-sample len.
    vq.push_back(mk(1'b1, 7'd2, 1'b0, 8'h00, 32'd0, F_LOAD, 1'b0, 32'd0));
    vq.push_back(mk(1'b1, 7'd5, 1'b1, 8'h11, 32'd0, F_LOAD, 1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'h22, 32'd0, F_LOAD, 1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'h33, 32'd0, F_LOAD, 1'b0, 32'd0));
    vq.push_back(mk(1'b0, 7'd0, 1'b1, 8'h44, 32'd0, F_LOAD, 1'b0, 32'd0));
    load_bytes(8'h55, 8'h66, 8'h77, 8'h88, F_RUN);
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'h00, 32'd0, F_RUN, 1'b1, 32'h44332211));
    vq.push_back(mk(1'b0, 7'd0, 1'b0, 8'h00, 32'd4, F_RUN, 1'b1, 32'h88776655));

    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      a = vq[i].addr;
      step(vq[i].st, vq[i].ln, vq[i].vl, vq[i].d);
      chk($sformatf("vec%0d_flags", i), {27'd0, flags()}, {27'd0, vq[i].f});
      if (vq[i].crd) chk($sformatf("vec%0d_rd", i), rd, vq[i].erd);
    end

    // Async reset after 5 bytes of a len=3 load.
    a = 32'd0;
    step(1'b1, 7'd3, 1'b0, 8'h00);
    step(1'b0, 7'd0, 1'b1, 8'hA1);
    step(1'b0, 7'd0, 1'b1, 8'hB2);
    step(1'b0, 7'd0, 1'b1, 8'hC3);
    step(1'b0, 7'd0, 1'b1, 8'hD4);
    step(1'b0, 7'd0, 1'b1, 8'hE5);
    chk("load_before_reset", {27'd0, flags()}, {27'd0, F_LOAD});
    #3 reset = 1'b1;
    #1;
    chk("async_reset_flags", {27'd0, flags()}, {27'd0, F_IDLE});
    chk("async_reset_ram0", rd, 32'hD4C3B2A1);
    #1 reset = 1'b0;

    // err is cleared by an asynchronous reset.
    step(1'b1, 7'd0, 1'b0, 8'h00);
    chk("err_set", {27'd0, flags()}, {27'd0, F_IDLE_E});
    #3 reset = 1'b1;
    #1;
    chk("err_cleared_by_reset", {27'd0, flags()}, {27'd0, F_IDLE});
    #1 reset = 1'b0;

    // First edge after reset accepts start; len=DEPTH is valid.
    step(1'b1, 7'd64, 1'b0, 8'h00);
    chk("first_edge_start_len64", {27'd0, flags()}, {27'd0, F_LOAD});
    step(1'b0, 7'd0, 1'b1, 8'h0D);
    step(1'b0, 7'd0, 1'b1, 8'hF0);
    step(1'b0, 7'd0, 1'b1, 8'hFE);
    step(1'b0, 7'd0, 1'b1, 8'hCA);
    chk("len64_still_load", {27'd0, flags()}, {27'd0, F_LOAD});
    chk("len64_word0", rd, 32'hCAFEF00D);
    a = 32'd4;
    #1;
    chk("len64_word1_old", rd, 32'h88776655);

    drive(1'b0, 7'd0, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
